// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the hh:mm:ss clock core.
// The user can edit the running time one field at a time with button
// pulses. The edited value is then committed through the core's
// parallel-load port.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mode_btn/inc_btn/dec_btn    single-cycle button pulses
//   hour_cur/min_cur/sec_cur    running time from the clock core
//   hour_set/min_set/sec_set    shadow (edited) time -> core hour_in/min_in/sec_in
//   load_out                    parallel-load strobe -> core load_in
//   field_sel                   0 none, 1 hour, 2 min, 3 sec
//   busy                        high whenever not in RUN

// One shadow field: capture with clamp-to-0, plus wrapping inc/dec.
// Index 0 is hour, 1 is minute and 2 is second.
module clock_set_field #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap,
  input  logic       inc,
  input  logic       dec,
  input  logic [5:0] cur,
  output logic [5:0] val
);
  localparam logic [5:0] MAX_V = 6'(MAX);

  always_ff @(posedge clk) begin
    if (rst)                val <= '0;
    else if (cap)           val <= (cur > MAX_V) ? '0 : cur;
    else if (inc && !dec)   val <= (val == MAX_V) ? '0 : val + 6'd1;
    else if (dec && !inc)   val <= (val == '0) ? MAX_V : val - 6'd1;
  end
endmodule

module clock_set_ctrl #(
  parameter int HOUR_MAX    = 23,
  parameter int TIMEOUT     = 1000,
  parameter int LOAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [5:0] hour_cur,
  input  logic [5:0] min_cur,
  input  logic [5:0] sec_cur,
  output logic [5:0] hour_set,
  output logic [5:0] min_set,
  output logic [5:0] sec_set,
  output logic       load_out,
  output logic [1:0] field_sel,
  output logic       busy
);
  localparam int NUM_FIELDS = 3;
  // One counter serves as the idle timer in edit states and as the
  // load-strobe timer in COMMIT, so it is sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES);

  typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [NUM_FIELDS-1:0]              sel, fld_inc, fld_dec;
  logic                               cap;
  logic [NUM_FIELDS-1:0][5:0]         cur_v, set_v;

  assign cur_v    = {sec_cur, min_cur, hour_cur};
  assign hour_set = set_v[0];
  assign min_set  = set_v[1];
  assign sec_set  = set_v[2];

  // Field strobes. Mode wins over inc/dec, and inc+dec together cancels.
  always_comb begin
    sel = '0;
    case (state)
      SET_HOUR: sel = 3'b001;
      SET_MIN:  sel = 3'b010;
      SET_SEC:  sel = 3'b100;
      default:  sel = '0;
    endcase
    cap     = (state == RUN) && mode_btn;
    fld_inc = sel & {NUM_FIELDS{inc_btn & ~dec_btn & ~mode_btn}};
    fld_dec = sel & {NUM_FIELDS{dec_btn & ~inc_btn & ~mode_btn}};
  end

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_fld
    clock_set_field #(.MAX((gi == 0) ? HOUR_MAX : 59)) u_fld (
      .clk (clk),
      .rst (rst),
      .cap (cap),
      .inc (fld_inc[gi]),
      .dec (fld_dec[gi]),
      .cur (cur_v[gi]),
      .val (set_v[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      load_out  <= 1'b0;
      field_sel <= 2'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mode_btn) begin
            state     <= SET_HOUR;
            field_sel <= 2'd1;
            busy      <= 1'b1;
            cnt       <= '0;
          end
        end
        SET_HOUR, SET_MIN, SET_SEC: begin
          if (mode_btn) begin
            cnt <= '0;
            case (state)
              SET_HOUR: begin state <= SET_MIN; field_sel <= 2'd2; end
              SET_MIN:  begin state <= SET_SEC; field_sel <= 2'd3; end
              default:  begin state <= COMMIT;  field_sel <= 2'd0; end
            endcase
          end else if (inc_btn || dec_btn) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            // Abandon the edit; shadow registers keep their values.
            state     <= RUN;
            field_sel <= 2'd0;
            busy      <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          // The first COMMIT cycle has load low. After that the strobe is
          // high for LOAD_CYCLES edges, and busy drops together with it.
          if (cnt == LOAD_LAST) begin
            state    <= RUN;
            load_out <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
          end else begin
            load_out <= 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          field_sel <= 2'd0;
          busy      <= 1'b0;
          load_out  <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;
  localparam int HOUR_MAX    = 23;
  localparam int TIMEOUT     = 1000;
  localparam int LOAD_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic [5:0] hour_cur = '0, min_cur = '0, sec_cur = '0;
  logic [5:0] hour_set, min_set, sec_set;
  logic       load_out, busy;
  logic [1:0] field_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(.HOUR_MAX(HOUR_MAX), .TIMEOUT(TIMEOUT), .LOAD_CYCLES(LOAD_CYCLES)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .hour_cur(hour_cur), .min_cur(min_cur), .sec_cur(sec_cur),
    .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set),
    .load_out(load_out), .field_sel(field_sel), .busy(busy)
  );

  wire [21:0] dut_out = {hour_set, min_set, sec_set, load_out, field_sel, busy};

  // Behavioural model. phase 0 = running, 1..3 = editing field phase-1,
  // 4 = committing. age counts edges spent in the commit phase.
  int m_phase = 0, m_idle = 0, m_age = 0;
  int m_v[3] = '{0, 0, 0};

  function automatic int fmax(int f);
    return (f == 0) ? HOUR_MAX : 59;
  endfunction

  function automatic logic [21:0] exp_out();
    logic [1:0] fs;
    logic       lo;
    fs = (m_phase >= 1 && m_phase <= 3) ? 2'(m_phase) : 2'd0;
    lo = (m_phase == 4) && (m_age >= 1) && (m_age <= LOAD_CYCLES);
    return {6'(m_v[0]), 6'(m_v[1]), 6'(m_v[2]), lo, fs, (m_phase != 0)};
  endfunction

  task automatic model_step(bit r, bit m, bit i, bit d, int hc, int mc, int sc);
    int cur[3];
    cur = '{hc, mc, sc};
    if (r) begin
      m_phase = 0; m_idle = 0; m_age = 0; m_v = '{0, 0, 0};
    end else if (m_phase == 0) begin
      if (m) begin
        for (int f = 0; f < 3; f++) m_v[f] = (cur[f] > fmax(f)) ? 0 : cur[f];
        m_phase = 1; m_idle = 0;
      end
    end else if (m_phase <= 3) begin
      if (m) begin
        m_phase++; m_idle = 0; m_age = 0;
      end else if (i || d) begin
        if (i && !d) m_v[m_phase-1] = (m_v[m_phase-1] + 1) % (fmax(m_phase-1) + 1);
        if (d && !i) m_v[m_phase-1] = (m_v[m_phase-1] + fmax(m_phase-1)) % (fmax(m_phase-1) + 1);
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle >= TIMEOUT) m_phase = 0;
      end
    end else begin
      m_age++;
      if (m_age > LOAD_CYCLES) m_phase = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the sampling edge,
  // then settle 1 time unit past the edge so outputs can be compared.
  task automatic cyc(bit r, bit m, bit i, bit d);
    rst = r; mode_btn = m; inc_btn = i; dec_btn = d;
    @(posedge clk);
    model_step(r, m, i, d, int'(hour_cur), int'(min_cur), int'(sec_cur));
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 1, 1);
      checks++;
      if (dut_out !== 22'd0) begin
        errors++; $display("FAIL reset_hold cyc %0d got %h exp 0", k, dut_out);
      end
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (dut_out !== 22'd0 || dut_out !== exp_out()) begin
      errors++; $display("FAIL reset_release got %h exp %h", dut_out, exp_out());
    end
  endtask

  task automatic test_capture_commit();
    int loads = 0;
    hour_cur = 6'd5; min_cur = 6'd14; sec_cur = 6'd33;
    cyc(0, 1, 0, 0);
    checks++;
    if ({hour_set, min_set, sec_set, field_sel, busy} !== {6'd5, 6'd14, 6'd33, 2'd1, 1'b1}) begin
      errors++; $display("FAIL capture got %h exp %h", dut_out, exp_out());
    end
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
    checks++;
    if (dut_out !== exp_out() || load_out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL commit_entry got %h exp %h", dut_out, exp_out());
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0);
      if (load_out === 1'b1) loads++;
      checks++;
      if (dut_out !== exp_out()) begin
        errors++; $display("FAIL commit_seq cyc %0d got %h exp %h", k, dut_out, exp_out());
      end
    end
    checks++;
    if (loads != 2 || busy !== 1'b0 || {hour_set, min_set, sec_set} !== {6'd5, 6'd14, 6'd33}) begin
      errors++; $display("FAIL commit_width got loads %0d busy %b exp loads 2 busy 0", loads, busy);
    end
  endtask

  task automatic test_wrap();
    hour_cur = 6'd23; min_cur = 6'd0; sec_cur = 6'd59;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if (hour_set !== 6'd0) begin errors++; $display("FAIL hour_inc_wrap got %0d exp 0", hour_set); end
    cyc(0, 0, 0, 1);
    checks++;
    if (hour_set !== 6'd23) begin errors++; $display("FAIL hour_dec_wrap got %0d exp 23", hour_set); end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if (min_set !== 6'd59) begin errors++; $display("FAIL min_dec_wrap got %0d exp 59", min_set); end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if (sec_set !== 6'd0) begin errors++; $display("FAIL sec_inc_wrap got %0d exp 0", sec_set); end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if ({hour_set, min_set, sec_set, load_out} !== {6'd23, 6'd59, 6'd0, 1'b1} || dut_out !== exp_out()) begin
      errors++; $display("FAIL wrap_load got %h exp %h", dut_out, exp_out());
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    int loads = 0;
    hour_cur = 6'd7; min_cur = 6'd8; sec_cur = 6'd9;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    checks++;
    if (hour_set !== 6'd7 || field_sel !== 2'd1) begin
      errors++; $display("FAIL inc_dec_cancel got hour %0d sel %0d exp 7 1", hour_set, field_sel);
    end
    cyc(0, 1, 1, 0);
    checks++;
    if (hour_set !== 6'd7 || field_sel !== 2'd2) begin
      errors++; $display("FAIL mode_wins got hour %0d sel %0d exp 7 2", hour_set, field_sel);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 0);
      if (load_out === 1'b1) loads++;
      if (busy === 1'b0) break;
    end
    checks++;
    if (loads != LOAD_CYCLES || dut_out !== exp_out()) begin
      errors++; $display("FAIL commit_ignores_btn got loads %0d out %h exp loads 2 out %h", loads, dut_out, exp_out());
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    bit saw_load = 0;
    hour_cur = 6'd30; min_cur = 6'd61; sec_cur = 6'd12;
    cyc(0, 1, 0, 0);
    checks++;
    if ({hour_set, min_set, sec_set} !== {6'd0, 6'd0, 6'd12}) begin
      errors++; $display("FAIL illegal_capture got %h exp 0/0/12", {hour_set, min_set, sec_set});
    end
    cyc(0, 1, 0, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      cyc(0, 0, 0, 0);
      if (load_out !== 1'b0) saw_load = 1;
    end
    checks++;
    if (field_sel !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early got sel %0d busy %b exp 2 1", field_sel, busy);
    end
    cyc(0, 0, 0, 0);
    if (load_out !== 1'b0) saw_load = 1;
    checks++;
    if (busy !== 1'b0 || field_sel !== 2'd0 || saw_load || dut_out !== exp_out()) begin
      errors++; $display("FAIL timeout_return got busy %b load_seen %b out %h exp %h", busy, saw_load, dut_out, exp_out());
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int k = 1; k < TIMEOUT - 1; k++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (field_sel !== 2'd2 || dut_out !== exp_out()) begin
      errors++; $display("FAIL timeout_rearm got sel %0d out %h exp 2 out %h", field_sel, dut_out, exp_out());
    end
    cyc(1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_commit();
    int wait_n = 0;
    hour_cur = 6'd12; min_cur = 6'd34; sec_cur = 6'd56;
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0);
    while (load_out !== 1'b1 && wait_n < 10) begin
      cyc(0, 0, 0, 0);
      wait_n++;
    end
    checks++;
    if (load_out !== 1'b1) begin
      errors++; $display("FAIL reach_load got %b exp 1 within 10 cycles", load_out);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (dut_out !== 22'd0) begin
      errors++; $display("FAIL reset_mid_commit got %h exp 0", dut_out);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      bit r, m, i, d;
      if ($urandom_range(0, 7) == 0) begin
        hour_cur = 6'($urandom_range(0, 63));
        min_cur  = 6'($urandom_range(0, 63));
        sec_cur  = 6'($urandom_range(0, 63));
      end
      r = ($urandom_range(0, 299) == 0);
      m = ($urandom_range(0, 5) == 0);
      i = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      cyc(r, m, i, d);
      checks++;
      if (dut_out !== exp_out()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", k, dut_out, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture_commit();
    test_wrap();
    test_simultaneous();
    test_timeout();
    test_reset_mid_commit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the hours/minutes/seconds clock datapath. It takes the running time from the clock's outputs, lets a user edit hour, minute and second in turn with single-cycle button pulses, and commits the edited value by driving the clock's parallel-load inputs. It sits between the button debouncers and the clock core: its `*_set` outputs feed the clock's `hour_in/min_in/sec_in`, and `load_out` feeds `load_in`.

## Interface
- `HOUR_MAX`, default 23: largest legal hour value; the hour field wraps to 0 after this.
- `TIMEOUT`, default 1000: idle cycles in an edit state before the edit is abandoned; must be ≥1.
- `LOAD_CYCLES`, default 2: number of consecutive cycles `load_out` is held high on commit; must be ≥1.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `mode_btn` in 1: one-cycle pulse; enter edit mode or advance to the next field.
- `inc_btn` in 1: one-cycle pulse; increment the selected field.
- `dec_btn` in 1: one-cycle pulse; decrement the selected field.
- `hour_cur` in 6: current hour from the clock core.
- `min_cur` in 6: current minute from the clock core.
- `sec_cur` in 6: current second from the clock core.
- `hour_set` out 6: edited hour; drives the clock core's `hour_in`.
- `min_set` out 6: edited minute; drives the clock core's `min_in`.
- `sec_set` out 6: edited second; drives the clock core's `sec_in`.
- `load_out` out 1: parallel-load strobe to the clock core.
- `field_sel` out 2: selected field; 0=none, 1=hour, 2=min, 3=sec.
- `busy` out 1: high in every state except RUN.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- **RUN**
  - `mode_btn` captures `*_cur` into the shadow registers (`*_set`) and moves to SET_HOUR.
  - A captured value above its maximum (hour > `HOUR_MAX`, min/sec > 59) is stored as 0.
  - `inc_btn` and `dec_btn` are ignored.
- **SET_HOUR / SET_MIN / SET_SEC**
  - `inc_btn` adds 1 to the selected field; the maximum wraps to 0.
  - `dec_btn` subtracts 1; 0 wraps to the maximum (`HOUR_MAX` for hour, 59 for min/sec).
  - `inc_btn` and `dec_btn` in the same cycle: no change, but the idle timer still resets.
  - `mode_btn` advances SET_HOUR→SET_MIN→SET_SEC→COMMIT. If `mode_btn` coincides with `inc_btn` or `dec_btn`, mode wins and the field is not modified.
  - The idle counter resets to 0 on entry and on any button pulse, and increments otherwise.
  - When the counter reaches `TIMEOUT`, the controller returns to RUN without loading. Shadow registers keep their values.
- **COMMIT**
  - `load_out`=1 for exactly `LOAD_CYCLES` cycles, then the controller returns to RUN.
  - All buttons are ignored in COMMIT.
  - `*_set` is stable throughout COMMIT.
- Unused 6-bit codes are never produced on `*_set`; all field values stay in legal range.
- `field_sel` encoding: RUN and COMMIT → 0; SET_HOUR → 1; SET_MIN → 2; SET_SEC → 3.

## Timing
- All outputs are registered.
- Reset values: state RUN, `hour_set`=`min_set`=`sec_set`=0, `load_out`=0, `field_sel`=0, `busy`=0, idle counter 0.
- `rst` asserted mid-edit or mid-COMMIT: on the next edge, all reset values apply and `load_out` drops immediately, even if the commit is partial.
- Edge numbering below: "edge N" is the rising edge that samples the event.
- A `mode_btn` pulse sampled at edge N in RUN: `busy`=1, `field_sel`=1 and captured values are visible after edge N.
- `inc_btn`/`dec_btn` sampled at edge N: the updated field is visible after edge N (1-cycle latency).
- `mode_btn` sampled at edge N in SET_SEC: `load_out`=1 after edges N+1 … N+`LOAD_CYCLES`, returning to 0 after edge N+`LOAD_CYCLES`+1.
  - `field_sel`=0 and `busy`=1 during COMMIT.
  - `busy` falls together with `load_out`.
- Timeout: with no button pulse after entry at edge E, state is RUN after edge E+`TIMEOUT`.
- Button inputs are pulses; a level held high acts as one pulse per cycle.

## Test plan
- **Reset:** hold `rst` for 5 cycles with all buttons high → all outputs 0 and state RUN during and after reset.
- **Capture and commit:** `hour_cur`=5, `min_cur`=14, `sec_cur`=33; send mode, mode, mode, mode → `hour_set`=5, `min_set`=14, `sec_set`=33; `load_out` high for exactly 2 cycles, then `busy`=0.
- **Wrap:**
  - Capture hour 23, inc → 0, then dec → 23.
  - In SET_MIN, capture min 0, dec → 59.
  - In SET_SEC, capture sec 59, inc → 0.
  - Commit → loaded values 23/59/0.
- **Simultaneous events:**
  - In SET_HOUR, inc+dec together → hour unchanged.
  - mode+inc together → `field_sel` becomes 2 and hour unchanged.
  - mode during COMMIT → ignored; `load_out` width stays 2.
- **Timeout and illegal capture:**
  - `hour_cur`=30 captures as 0.
  - Enter SET_MIN, then idle 1000 cycles → RUN with `load_out` never asserted.
  - Repeat with an inc at idle cycle 999 → still in SET_MIN at cycle 1000.
- **Reset mid-commit:** assert `rst` in the first `load_out` cycle → `load_out`=0, `*_set`=0 and state RUN on the next edge.
